// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared constants and sizing helpers for the Johnson sequence generator
//
// Purpose
//   Direction encodings and width helpers used by johnson_seq_counter and
//   johnson_code_check so both agree on sequence length and index width.
//
// Contents
//   DIR_FWD / DIR_REV  encodings of the dir input
//   seq_len(w)         number of legal codes in a w-bit twisted ring (2*w)
//   idx_w(w)           bits needed to hold a step index 0..seq_len(w)-1
package johnson_pkg;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  function automatic int seq_len(input int w);
    return 2 * w;
  endfunction

  function automatic int idx_w(input int w);
    return $clog2(2 * w);
  endfunction

endpackage

// File: rtl/johnson_code_check.sv
// rtl/johnson_code_check.sv - combinational legality check and step-index decode of a Johnson code
//
// Purpose
//   Classifies a WIDTH-bit code as a legal twisted-ring state or not, and for
//   legal codes reports which step (0..2*WIDTH-1) of the forward cycle it is.
//
// Ports
//   i_code     in   WIDTH   code under test
//   o_illegal  out  1       code has more than one adjacent-bit transition
//   o_idx      out  IDXW    step index; 0 for the all-zeros code and for illegal codes
module johnson_code_check
  import johnson_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int IDXW  = 3
) (
  input  logic [WIDTH-1:0] i_code,
  output logic             o_illegal,
  output logic [IDXW-1:0]  o_idx
);

  int w_pop;
  int w_trans;

  // A Johnson code is a single run of ones anchored at one end, so it has at
  // most one boundary between neighbouring bits that differ.
  always_comb begin
    w_pop   = 0;
    w_trans = 0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + int'(i_code[i]);
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      w_trans = w_trans + int'(i_code[i] ^ i_code[i+1]);
    end
  end

  assign o_illegal = (w_trans > 1);

  // Filling phase (ones anchored at the LSB) counts up with the number of
  // ones; draining phase (ones anchored at the MSB) counts down from 2*WIDTH.
  always_comb begin
    o_idx = '0;
    if (!o_illegal && (i_code != '0)) begin
      if (i_code[0]) begin
        o_idx = IDXW'(w_pop);
      end else begin
        o_idx = IDXW'(seq_len(WIDTH) - w_pop);
      end
    end
  end

endmodule

// File: rtl/johnson_seq_counter.sv
// rtl/johnson_seq_counter.sv - parametrised Johnson sequence generator with wrap pulse and cycle counter
//
// Purpose
//   Steps a WIDTH-bit twisted-ring code forward or backward through its
//   2*WIDTH states, flags the return to all-zeros with a registered wrap
//   pulse, counts completed cycles and recovers from illegal codes.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous active-high reset
//   en         in   1       advance one step this cycle
//   dir        in   1       DIR_FWD: shift left, LSB <= ~MSB; DIR_REV: shift right, MSB <= ~LSB
//   clr        in   1       synchronous clear (highest priority)
//   load       in   1       synchronous load of load_val (below clr, above en)
//   load_val   in   WIDTH   raw value to load, kept even if illegal
//   q          out  WIDTH   current code
//   idx        out  IDXW    step index decoded from q
//   wrap       out  1       one-cycle pulse aligned with q returning to zero by a step
//   seq_count  out  CNT_W   completed cycles, modulo 2^CNT_W
//   illegal    out  1       q is not a Johnson code
//   err        out  1       sticky: an illegal code was recovered
module johnson_seq_counter
  import johnson_pkg::*;
#(
  parameter  int WIDTH = 3,
  parameter  int CNT_W = 16,
  localparam int IDXW  = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [IDXW-1:0]  idx,
  output logic             wrap,
  output logic [CNT_W-1:0] seq_count,
  output logic             illegal,
  output logic             err
);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [CNT_W-1:0] r_seq_count;
  logic             r_err;

  logic [WIDTH-1:0] w_step_fwd;
  logic [WIDTH-1:0] w_step_rev;
  logic [WIDTH-1:0] w_step;
  logic             w_illegal;
  logic [IDXW-1:0]  w_idx;
  logic             w_terminal;

  johnson_code_check #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_code_check (
    .i_code    (r_q),
    .o_illegal (w_illegal),
    .o_idx     (w_idx)
  );

  assign w_step_fwd = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
  assign w_step_rev = {~r_q[0], r_q[WIDTH-1:1]};
  assign w_step     = (dir == DIR_REV) ? w_step_rev : w_step_fwd;

  // Only a legal step can land on zero as a cycle completion; the recovery
  // path also produces zero but must neither pulse wrap nor count.
  assign w_terminal = en && !w_illegal && (w_step == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q         <= '0;
      r_wrap      <= 1'b0;
      r_seq_count <= '0;
      r_err       <= 1'b0;
    end else if (clr) begin
      r_q         <= '0;
      r_wrap      <= 1'b0;
      r_seq_count <= '0;
      r_err       <= 1'b0;
    end else if (load) begin
      r_q    <= load_val;
      r_wrap <= 1'b0;
    end else if (en) begin
      if (w_illegal) begin
        r_q    <= '0;
        r_err  <= 1'b1;
        r_wrap <= 1'b0;
      end else begin
        r_q    <= w_step;
        r_wrap <= w_terminal;
        if (w_terminal) begin
          r_seq_count <= r_seq_count + CNT_W'(1);
        end
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign q         = r_q;
  assign wrap      = r_wrap;
  assign seq_count = r_seq_count;
  assign err       = r_err;
  assign illegal   = w_illegal;
  assign idx       = w_idx;

endmodule

// File: tb/tb_johnson_seq_counter.sv
// tb/tb_johnson_seq_counter.sv - scoreboard bench for johnson_seq_counter at WIDTH 3 and 4
module tb_johnson_seq_counter;

  typedef struct {
    int q;
    int idx;
    int wrap;
    int cnt;
    int ill;
    int err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] lv = 4'd0;

  logic [2:0]  q3;
  logic [2:0]  idx3;
  logic        wrap3;
  logic [1:0]  cnt3;
  logic        ill3;
  logic        err3;

  logic [3:0]  q4;
  logic [2:0]  idx4;
  logic        wrap4;
  logic [15:0] cnt4;
  logic        ill4;
  logic        err4;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t sb3[$];
  exp_t sb4[$];

  int mq[2];
  int mcnt[2];
  int merr[2];
  int w_of[2] = '{3, 4};
  int cw_of[2] = '{2, 16};

  always #5 clk = ~clk;

  johnson_seq_counter #(.WIDTH(3), .CNT_W(2)) dut3 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(lv[2:0]), .q(q3), .idx(idx3), .wrap(wrap3), .seq_count(cnt3),
    .illegal(ill3), .err(err3)
  );

  johnson_seq_counter #(.WIDTH(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(lv), .q(q4), .idx(idx4), .wrap(wrap4), .seq_count(cnt4),
    .illegal(ill4), .err(err4)
  );

  // Code at step k of the forward cycle: k ones filling from the LSB for
  // k <= w, then 2w-k ones left at the top while draining.
  function automatic int code_of(input int w, input int k);
    if (k <= w) return (1 << k) - 1;
    return ((1 << (2 * w - k)) - 1) << (k - w);
  endfunction

  function automatic int find_k(input int w, input int code);
    for (int k = 0; k < 2 * w; k++) begin
      if (code_of(w, k) == code) return k;
    end
    return -1;
  endfunction

  function automatic exp_t model_step(input int d, input bit e, input bit dr,
                                      input bit c, input bit l, input int v);
    exp_t x;
    int w;
    int n;
    int k;
    int k2;
    w = w_of[d];
    n = 2 * w;
    k = find_k(w, mq[d]);
    x.wrap = 0;
    if (c) begin
      mq[d] = 0; mcnt[d] = 0; merr[d] = 0;
    end else if (l) begin
      mq[d] = v & ((1 << w) - 1);
    end else if (e) begin
      if (k < 0) begin
        mq[d] = 0; merr[d] = 1;
      end else begin
        k2 = dr ? (k + n - 1) % n : (k + 1) % n;
        mq[d] = code_of(w, k2);
        if (k2 == 0) begin
          x.wrap = 1;
          mcnt[d] = (mcnt[d] + 1) % (1 << cw_of[d]);
        end
      end
    end
    k = find_k(w, mq[d]);
    x.q   = mq[d];
    x.idx = (k < 0) ? 0 : k;
    x.ill = (k < 0) ? 1 : 0;
    x.cnt = mcnt[d];
    x.err = merr[d];
    return x;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb3.size() > 0) begin
      e = sb3.pop_front();
      check("w3_q", int'(q3), e.q);
      check("w3_idx", int'(idx3), e.idx);
      check("w3_wrap", int'(wrap3), e.wrap);
      check("w3_seq_count", int'(cnt3), e.cnt);
      check("w3_illegal", int'(ill3), e.ill);
      check("w3_err", int'(err3), e.err);
    end
    if (sb4.size() > 0) begin
      e = sb4.pop_front();
      check("w4_q", int'(q4), e.q);
      check("w4_idx", int'(idx4), e.idx);
      check("w4_wrap", int'(wrap4), e.wrap);
      check("w4_seq_count", int'(cnt4), e.cnt);
      check("w4_illegal", int'(ill4), e.ill);
      check("w4_err", int'(err4), e.err);
    end
  end

  task automatic step(input bit e, input bit dr, input bit c, input bit l, input int v);
    @(negedge clk);
    en = e; dir = dr; clr = c; load = l; lv = v[3:0];
    sb3.push_back(model_step(0, e, dr, c, l, v));
    sb4.push_back(model_step(1, e, dr, c, l, v));
    @(posedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_q3"}, int'(q3), 0);
    check({tag, "_cnt3"}, int'(cnt3), 0);
    check({tag, "_wrap3"}, int'(wrap3), 0);
    check({tag, "_err3"}, int'(err3), 0);
    check({tag, "_idx3"}, int'(idx3), 0);
    check({tag, "_ill3"}, int'(ill3), 0);
    check({tag, "_q4"}, int'(q4), 0);
    check({tag, "_cnt4"}, int'(cnt4), 0);
    check({tag, "_err4"}, int'(err4), 0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    en = 0; clr = 0; load = 0;
    #2 rst = 1'b1;
    #1 check_reset_state("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mq[d] = 0; mcnt[d] = 0; merr[d] = 0;
    end
  endtask

  initial begin
    bit rd;
    for (int d = 0; d < 2; d++) begin
      mq[d] = 0; mcnt[d] = 0; merr[d] = 0;
    end
    #12 check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    // forward walk from reset, then reverse walk
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0);

    // illegal load, recovery, clear of err
    step(0, 0, 0, 1, 2);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);

    // clr beats load beats en
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 3);
    step(1, 1, 0, 1, 3);
    step(1, 0, 0, 0, 0);

    // five full forward cycles exercise the 2-bit counter rollover
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 30; i++) step(1, 0, 0, 0, 0);

    // async reset mid-sequence at 111, then resume
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    async_reset();
    step(1, 0, 0, 0, 0);

    // direction change at 111 walks back to 000 with a wrap
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);

    // randomized traffic with occasional clears, loads, holds and reversals
    rd = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 12) rd = ~rd;
      step($urandom_range(0, 99) < 80, rd, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 8, int'($urandom_range(0, 15)));
      if ($urandom_range(0, 99) < 5) begin
        @(negedge clk);
        en = 0; clr = 0; load = 0;
        for (int d = 0; d < 2; d++) begin
          sb3.push_back(model_step(0, 0, rd, 0, 0, 0));
          sb4.push_back(model_step(1, 0, rd, 0, 0, 0));
          @(posedge clk);
        end
      end
    end

    @(negedge clk);
    en = 0; clr = 0; load = 0;
    repeat (3) @(negedge clk);
    check("sb3_drained", sb3.size(), 0);
    check("sb4_drained", sb4.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
